pu_mult_driver: RTL and testbench
=================================

Name: pu_mult_driver

Overview:
- Initiator side of the multiplier PU bus (signal_wr/signal_sel/data_in/attr_in write port, signal_oe/data_out/attr_out read port).
- Accepts one operand pair over a valid/ready stream, writes operand 0 then operand 1 into the PU, waits out the PU result latency, then reads the result with signal_oe.
- Returns the product and its invalid flag over a valid/ready output stream.
- Used as a standalone host for the multiplier PU in block-level tests and in small non-microcoded datapaths.

Parameters:
DATA_WIDTH, 32, width of the PU data bus and of in_a, in_b and out_data
ATTR_WIDTH, 4, PU attribute bus is ATTR_WIDTH+1 bits
INVALID, 0, bit index of the invalid flag within the attribute bus
LATENCY, 2, cycles with wr=0, sel=0 between the operand-1 write and the read cycle; must be >=2
CNT_WIDTH, 16, width of ops_done

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operand pair offered
in_ready  out  1  driver can accept a pair
in_a  in  DATA_WIDTH  operand 0
in_b  in  DATA_WIDTH  operand 1
in_a_invalid  in  1  invalid flag for operand 0
in_b_invalid  in  1  invalid flag for operand 1
out_valid  out  1  result held for consumer
out_ready  in  1  consumer accepts result
out_data  out  DATA_WIDTH  product read from PU
out_invalid  out  1  PU attr bit INVALID captured with the product
pu_signal_wr  out  1  PU write strobe
pu_signal_sel  out  1  PU operand select
pu_data_in  out  DATA_WIDTH  PU write data
pu_attr_in  out  ATTR_WIDTH+1  PU write attributes
pu_signal_oe  out  1  PU output enable
pu_data_out  in  DATA_WIDTH  PU read data, combinational from PU
pu_attr_out  in  ATTR_WIDTH+1  PU read attributes
busy  out  1  state != IDLE
ops_done  out  CNT_WIDTH  completed output handshakes

Behaviour:
- FSM states: IDLE, WR_A, WR_B, WAIT, READ, HOLD. Registered state; PU outputs are decoded from state, glitch-free.
- Reset: state=IDLE; in_ready=1; out_valid=0; out_data=0; out_invalid=0; ops_done=0; all pu_* outputs=0. Reset has priority over every other event, including mid-operation. The PU is reset by the same rst, so no cleanup sequence is issued.
- IDLE:
  - in_ready=1, pu_* outputs=0.
  - On in_valid&in_ready: latch in_a, in_b and both flags; go to WR_A.
- WR_A (1 cycle): wr=1, sel=0, data_in=a, attr_in=a_invalid<<INVALID, other attr bits 0. Go to WR_B.
- WR_B (1 cycle): wr=1, sel=1, data_in=b, attr_in=b_invalid<<INVALID. Go to WAIT and load wait counter with LATENCY-1.
- WAIT:
  - Duration is exactly LATENCY cycles: wr=0, sel=0, data_in=0, attr_in=0.
  - The 1->0 falling edge of sel triggers the PU result capture.
  - Counter decrements each cycle; at 0 go to READ.
- READ (1 cycle):
  - oe=1, sel=0, wr=0.
  - At the closing edge: out_data<=pu_data_out, out_invalid<=pu_attr_out[INVALID], out_valid<=1. Go to HOLD.
- HOLD:
  - out_valid=1; out_data and out_invalid are stable.
  - On out_ready: out_valid<=0, ops_done<=ops_done+1 (wraps modulo 2^CNT_WIDTH), go to IDLE.
- Latency: input handshake at edge T gives WR_A in cycle T+1, READ in cycle T+3+LATENCY, out_valid=1 from cycle T+4+LATENCY.
- With out_ready held high, each transaction occupies LATENCY+5 cycles; the next pair is accepted in the IDLE cycle that follows.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored; the pair stays pending at the source.
- out_ready while out_valid=0 has no effect.
- No arithmetic is performed in the driver. Operands are forwarded unmodified; range checking is the PU's job.
- pu_signal_oe is never high in the same cycle as pu_signal_wr.

Test Plan:
- Reset, then a=3, b=5, flags 0, out_ready=1. Required: wr/sel sequence (1,0),(1,1),(0,0),(0,0); oe=1 in cycle T+5; out_valid at T+6 with out_data=15, out_invalid=0; ops_done=1.
- Signed operands a=0xFFFFFFFC (-4), b=7. Required: out_data=0xFFFFFFE4 (-28); pu_attr_in=0 during both write cycles.
- a_invalid=1, a=2, b=2. Required: pu_attr_in=0x01 in WR_A; out_invalid equals pu_attr_out[0] sampled in READ.
- Hold out_ready=0 for 6 cycles after out_valid rises. Required: out_valid and out_data stable, in_ready=0, pu_* all 0; a new in_valid is not accepted. Raise out_ready: one handshake, ops_done increments by exactly 1.
- Assert rst in the second WAIT cycle. Required: next cycle state=IDLE, busy=0, out_valid=0, pu_* outputs=0. A following pair a=6, b=7 yields 42.
- Run 2^CNT_WIDTH+1 back-to-back operations (CNT_WIDTH=4 build). Required: ops_done wraps to 1; throughput is one result per LATENCY+5 cycles.

Source files
------------

// File: rtl/pu_mult_driver.sv
// pu_mult_driver: initiator for the multiplier PU bus.
// Takes one operand pair, writes both operands into the PU, waits out the PU
// result latency, reads the product back and offers it on an output stream.
//
// state | meaning
// IDLE  | ready for a new operand pair, PU bus quiet
// WR_A  | writing operand 0 (sel=0)
// WR_B  | writing operand 1 (sel=1)
// WAIT  | LATENCY quiet cycles; sel falling edge starts PU capture
// READ  | oe=1, product sampled at the closing edge
// HOLD  | result offered until the consumer takes it
module pu_mult_driver #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int INVALID    = 0,
  parameter int LATENCY    = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_a_invalid,
  input  logic                  in_b_invalid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_invalid,
  output logic                  pu_signal_wr,
  output logic                  pu_signal_sel,
  output logic [DATA_WIDTH-1:0] pu_data_in,
  output logic [ATTR_WIDTH:0]   pu_attr_in,
  output logic                  pu_signal_oe,
  input  logic [DATA_WIDTH-1:0] pu_data_out,
  input  logic [ATTR_WIDTH:0]   pu_attr_out,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  ops_done
);

  localparam int WCW = $clog2(LATENCY + 1);
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WAIT, READ, HOLD} state_t;

  state_t                state;
  logic [WCW-1:0]        wait_cnt;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  b_invalid_q;

  // Only the invalid bit of the attribute bus is driven; the rest stay zero.
  function automatic logic [ATTR_WIDTH:0] attr_of(input logic flag);
    logic [ATTR_WIDTH:0] v;
    v          = '0;
    v[INVALID] = flag;
    return v;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Sequencer: PU strobes are registered alongside the state so the bus
  // pins change only on clock edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      b_q           <= '0;
      b_invalid_q   <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_invalid   <= 1'b0;
      ops_done      <= '0;
      pu_signal_wr  <= 1'b0;
      pu_signal_sel <= 1'b0;
      pu_data_in    <= '0;
      pu_attr_in    <= '0;
      pu_signal_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            b_q           <= in_b;
            b_invalid_q   <= in_b_invalid;
            pu_signal_wr  <= 1'b1;
            pu_signal_sel <= 1'b0;
            pu_data_in    <= in_a;
            pu_attr_in    <= attr_of(in_a_invalid);
            state         <= WR_A;
          end
        end
        WR_A: begin
          pu_signal_sel <= 1'b1;
          pu_data_in    <= b_q;
          pu_attr_in    <= attr_of(b_invalid_q);
          state         <= WR_B;
        end
        WR_B: begin
          pu_signal_wr  <= 1'b0;
          pu_signal_sel <= 1'b0;
          pu_data_in    <= '0;
          pu_attr_in    <= '0;
          wait_cnt      <= WAIT_LOAD;
          state         <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            pu_signal_oe <= 1'b1;
            state        <= READ;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        READ: begin
          out_data     <= pu_data_out;
          out_invalid  <= pu_attr_out[INVALID];
          out_valid    <= 1'b1;
          pu_signal_oe <= 1'b0;
          state        <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ops_done  <= ops_done + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_mult_driver.sv
// Bench for pu_mult_driver: behavioural multiplier PU plus scoreboard of
// expected products, directed steps in one initial block.
module tb_pu_mult_driver;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int LAT = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_a_invalid, in_b_invalid;
  logic [DW-1:0] in_a, in_b;
  logic          out_valid, out_ready, out_invalid;
  logic [DW-1:0] out_data;
  logic          pu_signal_wr, pu_signal_sel, pu_signal_oe;
  logic [DW-1:0] pu_data_in, pu_data_out;
  logic [AW:0]   pu_attr_in, pu_attr_out;
  logic          busy;
  logic [CW-1:0] ops_done;

  pu_mult_driver #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .INVALID(0),
                   .LATENCY(LAT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_a_invalid(in_a_invalid), .in_b_invalid(in_b_invalid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_invalid(out_invalid),
    .pu_signal_wr(pu_signal_wr), .pu_signal_sel(pu_signal_sel),
    .pu_data_in(pu_data_in), .pu_attr_in(pu_attr_in),
    .pu_signal_oe(pu_signal_oe), .pu_data_out(pu_data_out),
    .pu_attr_out(pu_attr_out), .busy(busy), .ops_done(ops_done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier PU: latches operands on wr, multiplies on the
  // falling edge of sel, drives the result only while oe is high.
  logic [DW-1:0] m_a, m_b, m_res;
  logic          m_ai, m_bi, m_inv, m_sel_q;
  always @(posedge clk) begin
    if (rst) begin
      m_a <= '0; m_b <= '0; m_res <= '0; m_ai <= 0; m_bi <= 0; m_inv <= 0; m_sel_q <= 0;
    end else begin
      m_sel_q <= pu_signal_sel;
      if (pu_signal_wr && !pu_signal_sel) begin m_a <= pu_data_in; m_ai <= pu_attr_in[0]; end
      if (pu_signal_wr &&  pu_signal_sel) begin m_b <= pu_data_in; m_bi <= pu_attr_in[0]; end
      if (m_sel_q && !pu_signal_sel) begin m_res <= m_a * m_b; m_inv <= m_ai | m_bi; end
    end
  end
  assign pu_data_out = pu_signal_oe ? m_res : '0;
  assign pu_attr_out = pu_signal_oe ? {{AW{1'b0}}, m_inv} : '0;

  typedef struct { logic [DW-1:0] data; logic inv; } exp_t;
  exp_t exp_q[$];
  exp_t last_exp;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   exp_ops = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] pu_bus();
    return {pu_signal_wr, pu_signal_sel, pu_signal_oe, pu_data_in, pu_attr_in};
  endfunction

  // Offer a pair; handshake completes on the next edge once in_ready is seen.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic ai, input logic bi);
    exp_t e;
    int n = 0;
    in_a = a; in_b = b; in_a_invalid = ai; in_b_invalid = bi; in_valid = 1'b1;
    while (!in_ready && n < 40) begin step(); n++; end
    chk("in_ready_seen", in_ready, 1);
    step();
    in_valid = 1'b0;
    e.data = a * b;
    e.inv  = ai | bi;
    exp_q.push_back(e);
  endtask

  // Wait for out_valid and compare with the oldest expectation.
  task automatic recv(output int t_valid);
    int n = 0;
    t_valid = -1;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("out_valid_seen", out_valid, 1);
    if (out_valid && exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      chk("out_data", out_data, last_exp.data);
      chk("out_invalid", out_invalid, last_exp.inv);
      t_valid = cyc;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    exp_ops = (exp_ops + 1) % (1 << CW);
    chk("ops_done", ops_done, exp_ops);
    chk("out_valid_after_hs", out_valid, 0);
  endtask

  initial begin
    int t, t_prev, n;
    logic rd_inv;
    rst = 1; in_valid = 0; in_a = '0; in_b = '0; in_a_invalid = 0; in_b_invalid = 0;
    out_ready = 0;
    repeat (3) step();
    rst = 0;
    step();

    // Reset state.
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_invalid", out_invalid, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pu_bus", pu_bus(), 0);

    // 3*5 with cycle-exact bus sequence.
    out_ready = 1;
    send(3, 5, 0, 0);
    chk("t1_wra", {pu_signal_wr, pu_signal_sel, pu_signal_oe}, 3'b100);
    chk("t1_wra_data", pu_data_in, 3);
    chk("t1_in_ready", in_ready, 0);
    step();
    chk("t1_wrb", {pu_signal_wr, pu_signal_sel, pu_signal_oe}, 3'b110);
    chk("t1_wrb_data", pu_data_in, 5);
    step();
    chk("t1_wait1", pu_bus(), 0);
    step();
    chk("t1_wait2", pu_bus(), 0);
    step();
    chk("t1_read", {pu_signal_wr, pu_signal_sel, pu_signal_oe}, 3'b001);
    chk("t1_out_valid_read", out_valid, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    recv(t);
    accept();

    // Signed operands, attributes clear.
    send(32'hFFFF_FFFC, 7, 0, 0);
    chk("t2_attr_wra", pu_attr_in, 0);
    step();
    chk("t2_attr_wrb", pu_attr_in, 0);
    recv(t);
    accept();

    // Invalid flag on operand 0.
    send(2, 2, 1, 0);
    chk("t3_attr_wra", pu_attr_in, 1);
    n = 0;
    while (!pu_signal_oe && n < 20) begin step(); n++; end
    chk("t3_oe_seen", pu_signal_oe, 1);
    rd_inv = pu_attr_out[0];
    recv(t);
    chk("t3_inv_matches_read", out_invalid, rd_inv);
    accept();

    // Back-pressure: out_ready low for 6 cycles with a competing pair pending.
    out_ready = 0;
    send(11, 13, 0, 1);
    recv(t);
    in_a = 9; in_b = 9; in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, last_exp.data);
      chk("t4_hold_in_ready", in_ready, 0);
      chk("t4_hold_pu", pu_bus(), 0);
    end
    in_valid = 0;
    accept();
    chk("t4_idle", busy, 0);

    // Reset in the second WAIT cycle.
    send(100, 3, 0, 0);
    step();  // WR_B
    step();  // WAIT 1
    step();  // WAIT 2
    rst = 1;
    step();
    rst = 0;
    chk("t5_busy", busy, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_pu", pu_bus(), 0);
    chk("t5_ops_done", ops_done, 0);
    exp_q.delete();
    exp_ops = 0;
    send(6, 7, 0, 0);
    recv(t);
    accept();

    // 17 back-to-back operations with counter wrap.
    rst = 1; step(); rst = 0; step();
    exp_ops = 0;
    out_ready = 1;
    t_prev = -1;
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      recv(t);
      if (i > 0) chk("t6_period", t - t_prev, LAT + 5);
      t_prev = t;
      accept();
    end
    chk("t6_wrap", ops_done, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
